note_playback_sched: RTL

- Owns the single tone-generator input (note code to the scale/speaker block) and arbitrates between two requesters: live PS/2 key events and a recorded-phrase playback engine.
- Sits between the keyboard controller's decoded key events and the scale block.
- Records timed make/break events into an internal buffer, replays them with original timing, and forces silence on stop or reset.

---
 rtl/note_playback_sched.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/note_playback_sched.sv
// rtl/note_playback_sched.sv - live/playback arbiter for the tone generator note code
// Records timed key make/break events and replays them with their original ms spacing.
module note_playback_sched #(
  parameter int DEPTH    = 32,
  parameter int CODE_W   = 8,
  parameter int DUR_W    = 16,
  parameter int TICK_DIV = 100000
) (
  input  logic                   CLK,
  input  logic                   rst,
  input  logic                   key_valid,
  input  logic [CODE_W-1:0]      key_code,
  input  logic                   key_break,
  input  logic                   rec_start,
  input  logic                   play_start,
  input  logic                   stop,
  output logic [CODE_W-1:0]      note_code,
  output logic                   note_src,
  output logic [1:0]             state,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REC  = 2'd1,
    S_PLAY = 2'd2
  } state_t;

  state_t                     state_q;
  logic [CODE_W-1:0]          note_q;
  logic                       src_q;
  logic [CW-1:0]              count_q;
  logic [CW-1:0]              idx_q;
  logic [PW-1:0]              presc_q, presc_d;
  logic [DUR_W-1:0]           delta_q, delta_d;
  logic [CODE_W+DUR_W-1:0]    mem_q [DEPTH];

  logic                       tick;
  logic                       cmd_any;
  logic                       rec_hit;
  logic [CODE_W-1:0]          live_note;
  logic [CODE_W+DUR_W-1:0]    play_entry;
  logic [CODE_W-1:0]          entry_code;
  logic [DUR_W-1:0]           entry_delta;

  assign tick    = (presc_q == PW'(TICK_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + PW'(1);
  assign delta_d = (tick && (delta_q != '1)) ? delta_q + DUR_W'(1) : delta_q;

  // A key event coinciding with any command strobe is dropped entirely.
  assign cmd_any   = stop | rec_start | play_start;
  assign rec_hit   = (state_q == S_REC) && key_valid && !cmd_any;
  assign live_note = key_break ? ((key_code == note_q) ? '0 : note_q) : key_code;

  assign play_entry  = mem_q[idx_q[AW-1:0]];
  assign entry_code  = play_entry[DUR_W +: CODE_W];
  assign entry_delta = play_entry[DUR_W-1:0];

  always_ff @(posedge CLK) begin
    if (!rst && rec_hit)
      mem_q[count_q[AW-1:0]] <= {(key_break ? {CODE_W{1'b0}} : key_code), delta_q};
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= S_IDLE;
      note_q  <= '0;
      src_q   <= 1'b0;
      count_q <= '0;
      idx_q   <= '0;
      presc_q <= '0;
      delta_q <= '0;
    end else begin
      presc_q <= presc_d;
      delta_q <= delta_d;
      case (state_q)
        S_IDLE: begin
          if (stop) begin
            note_q <= '0;
          end else if (rec_start) begin
            state_q <= S_REC;
            presc_q <= '0;
            delta_q <= '0;
            count_q <= '0;
          end else if (play_start && (count_q != '0)) begin
            state_q <= S_PLAY;
            src_q   <= 1'b1;
            note_q  <= '0;
            idx_q   <= '0;
            presc_q <= '0;
            delta_q <= '0;
          end else if (key_valid && !cmd_any) begin
            note_q <= live_note;
          end
        end
        S_REC: begin
          if (stop) begin
            state_q <= S_IDLE;
            note_q  <= '0;
            presc_q <= '0;
          end else if (rec_hit) begin
            note_q  <= live_note;
            count_q <= count_q + CW'(1);
            delta_q <= '0;
            // The event that fills the buffer is kept and recording ends.
            if (count_q == CW'(DEPTH - 1)) begin
              state_q <= S_IDLE;
              presc_q <= '0;
            end
          end
        end
        S_PLAY: begin
          if (stop) begin
            state_q <= S_IDLE;
            note_q  <= '0;
            src_q   <= 1'b0;
            presc_q <= '0;
          end else if (idx_q < count_q) begin
            if (delta_q >= entry_delta) begin
              note_q  <= entry_code;
              idx_q   <= idx_q + CW'(1);
              delta_q <= '0;
              presc_q <= '0;
            end
          end else if (tick) begin
            // Last entry has been held for one tick.
            state_q <= S_IDLE;
            note_q  <= '0;
            src_q   <= 1'b0;
            presc_q <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign note_code = note_q;
  assign note_src  = src_q;
  assign state     = state_q;
  assign count     = count_q;
  assign full      = (count_q == CW'(DEPTH));

endmodule
